demux3_buf: RTL and testbench
=============================

Name: demux3_buf

Overview:
- 1-to-3 buffered demultiplexer; routes one 32-bit source stream to one of three destination ports, chosen by a 2-bit select.
- Select encoding matches the datapath's 3:1 mux: 00 -> port A, 01 -> port B, 10 -> port C, 11 -> invalid.
- Sits on the write side of the memory-stage input path. It distributes a single producer's data to three consumers, each with its own valid/ready handshake and one-entry holding register.

Parameters:
- BITWIDTH, 32, data width of the input and of each output port.
- DROP_CNT_W, 8, width of the saturating counter of invalid-select drops.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  source presents a word this cycle.
- in_ready  output  1  block accepts the word this cycle.
- in_sel  input  2  destination select: 00=A, 01=B, 10=C, 11=invalid.
- in_data  input  BITWIDTH  source word.
- a_valid / b_valid / c_valid  output  1  port holds a word.
- a_ready / b_ready / c_ready  input  1  consumer takes the word.
- a_data / b_data / c_data  output  BITWIDTH  port word.
- drop_pulse  output  1  one-cycle pulse when an invalid-select word is discarded.
- drop_cnt  output  DROP_CNT_W  saturating count of discarded words.

Behaviour:
- Reset (rst=1 at an edge):
  - all x_valid=0, all x_data=0, drop_pulse=0, drop_cnt=0.
  - Any buffered word is discarded.
  - rst takes priority over every other event in the same cycle.
- Handshakes:
  - Input transfer when in_valid and in_ready are both 1.
  - Output transfer when x_valid and x_ready are both 1.
  - x_data is held stable while x_valid=1 and x_ready=0.
- in_ready is combinational from in_sel and slot state, with no dependence on in_valid:
  - sel 00/01/10: in_ready = (target slot empty) OR (target x_ready=1).
  - sel 11: in_ready=1 always.
- Latency: a word accepted at edge N appears on x_data with x_valid=1 after edge N, i.e. one-cycle latency with no combinational in->out path.
- Slot update, per port, in priority order:
  1. Accept targeting this port: slot loads in_data, valid=1. This covers an empty slot, and a full slot draining in the same cycle (back-to-back, x_valid stays 1, new data replaces old).
  2. Else if output transfer: valid=0; data holds its last value.
  3. Else: hold.
- Non-targeted ports are unaffected by the input side. Each drains independently, so all three ports may transfer in the same cycle.
- Invalid select (sel=11 with in_valid=1):
  - Word consumed and dropped.
  - drop_pulse=1 in the following cycle.
  - drop_cnt increments, saturating at 2^DROP_CNT_W-1.
  - No slot is touched.
- Idle input: sel is don't-care when in_valid=0. No state change and no drop.
- Full target with x_ready=0: in_ready=0. The source must hold in_data and in_sel; the block keeps no state on stalled input.
- Throughput: one word per cycle sustained when every targeted consumer keeps x_ready=1.

Decomposition:
- Shared package:
  - select encodings SEL_A=2'b00, SEL_B=2'b01, SEL_C=2'b10, SEL_INV=2'b11.
  - default BITWIDTH. The existing 3:1 mux uses the same constants.
- One sub-module, demux_slot:
  - one-entry register with load/valid/ready logic, parameterized by BITWIDTH.
  - Instantiated three times.
  - Top level holds the select decode, in_ready mux and drop counter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> all x_valid=0, drop_cnt=0, in_ready=1 for sel 00/01/10/11.
- Single route: sel=01, data=0xDEADBEEF, b_ready=0 -> b_valid=1 and b_data=0xDEADBEEF one cycle later; a_valid=c_valid=0; a second sel=01 word sees in_ready=0 until b_ready=1.
- Back-to-back: sel=10, c_ready=1, data 1,2,3,4 on consecutive cycles -> in_ready stays 1; c_data=1,2,3,4 on consecutive cycles; c_valid stays 1 throughout.
- Invalid select: five words with sel=11 -> in_ready=1 each cycle, five drop_pulse cycles, drop_cnt=5, no x_valid asserted; with DROP_CNT_W=2, the count saturates at 3.
- Parallel drain: fill A=0x11, B=0x22, C=0x33 with all ready=0, then raise all readies together -> all three transfer in one cycle, then all x_valid=0.
- Reset mid-operation: B full with 0x55 and b_ready=0, assert rst together with an accepted sel=00 word -> next cycle all x_valid=0 and drop_cnt=0; the sel=00 word is not captured.

Source files
------------

// File: rtl/demux3_buf_pkg.sv
// demux3_buf_pkg: shared select encodings and default widths.
// Also used by the datapath 3:1 mux so that both sides decode the select the same way.
package demux3_buf_pkg;

    localparam int DEF_BITWIDTH   = 32;
    localparam int DEF_DROP_CNT_W = 8;

    typedef enum logic [1:0] {
        SEL_A   = 2'b00,
        SEL_B   = 2'b01,
        SEL_C   = 2'b10,
        SEL_INV = 2'b11
    } sel_e;

endpackage

// File: rtl/demux3_buf_if.sv
// demux3_buf_if: source handshake, three destination handshakes, drop status.
// master = producer/consumer side, slave = demux3_buf.
interface demux3_buf_if
    import demux3_buf_pkg::*;
#(
    parameter int BITWIDTH   = DEF_BITWIDTH,
    parameter int DROP_CNT_W = DEF_DROP_CNT_W
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_sel;
    logic [BITWIDTH-1:0]   in_data;
    logic                  a_valid;
    logic                  a_ready;
    logic [BITWIDTH-1:0]   a_data;
    logic                  b_valid;
    logic                  b_ready;
    logic [BITWIDTH-1:0]   b_data;
    logic                  c_valid;
    logic                  c_ready;
    logic [BITWIDTH-1:0]   c_data;
    logic                  drop_pulse;
    logic [DROP_CNT_W-1:0] drop_cnt;

    modport master (
        output in_valid, in_sel, in_data,
        output a_ready, b_ready, c_ready,
        input  in_ready,
        input  a_valid, a_data, b_valid, b_data, c_valid, c_data,
        input  drop_pulse, drop_cnt
    );

    modport slave (
        input  in_valid, in_sel, in_data,
        input  a_ready, b_ready, c_ready,
        output in_ready,
        output a_valid, a_data, b_valid, b_data, c_valid, c_data,
        output drop_pulse, drop_cnt
    );

endinterface

// File: rtl/demux3_buf_slot.sv
// demux_slot: one-entry output register with valid/ready handshake.
// Ports: clk, rst, load/din (fill), valid/ready/dout (drain).
module demux_slot #(
    parameter int BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [BITWIDTH-1:0] din,
    input  logic                ready,
    output logic                valid,
    output logic [BITWIDTH-1:0] dout
);

    // A load wins over a drain so a full slot can refill back-to-back.
    // On a plain drain the data is left in place.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/demux3_buf.sv
// demux3_buf: 1-to-3 buffered demux, one register slot per port, drops sel=11.
// Ports: clk, rst (sync, active high), bus (demux3_buf_if.slave).
module demux3_buf
    import demux3_buf_pkg::*;
#(
    parameter int BITWIDTH   = DEF_BITWIDTH,
    parameter int DROP_CNT_W = DEF_DROP_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    demux3_buf_if.slave   bus
);

    localparam logic [DROP_CNT_W-1:0] CNT_MAX = '1;

    logic [2:0] full;
    logic [2:0] rdy;
    logic [2:0] tgt;
    logic [2:0] load;
    logic       acc;
    logic       drop;
    logic       in_ready_c;

    assign full = {bus.c_valid, bus.b_valid, bus.a_valid};
    assign rdy  = {bus.c_ready, bus.b_ready, bus.a_ready};

    // Target decode and ready mux; never looks at in_valid.
    always_comb begin
        tgt        = 3'b000;
        in_ready_c = 1'b1;
        unique case (bus.in_sel)
            SEL_A: begin
                tgt        = 3'b001;
                in_ready_c = ~full[0] | rdy[0];
            end
            SEL_B: begin
                tgt        = 3'b010;
                in_ready_c = ~full[1] | rdy[1];
            end
            SEL_C: begin
                tgt        = 3'b100;
                in_ready_c = ~full[2] | rdy[2];
            end
            default: begin
                tgt        = 3'b000;
                in_ready_c = 1'b1;
            end
        endcase
    end

    assign bus.in_ready = in_ready_c;
    assign acc  = bus.in_valid & in_ready_c;
    assign load = tgt & {3{acc}};
    assign drop = acc & (bus.in_sel == SEL_INV);

    demux_slot #(.BITWIDTH(BITWIDTH)) u_slot_a (
        .clk   (clk),
        .rst   (rst),
        .load  (load[0]),
        .din   (bus.in_data),
        .ready (bus.a_ready),
        .valid (bus.a_valid),
        .dout  (bus.a_data)
    );

    demux_slot #(.BITWIDTH(BITWIDTH)) u_slot_b (
        .clk   (clk),
        .rst   (rst),
        .load  (load[1]),
        .din   (bus.in_data),
        .ready (bus.b_ready),
        .valid (bus.b_valid),
        .dout  (bus.b_data)
    );

    demux_slot #(.BITWIDTH(BITWIDTH)) u_slot_c (
        .clk   (clk),
        .rst   (rst),
        .load  (load[2]),
        .din   (bus.in_data),
        .ready (bus.c_ready),
        .valid (bus.c_valid),
        .dout  (bus.c_data)
    );

    // Drop pulse follows the discarded word by one cycle; count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.drop_pulse <= 1'b0;
            bus.drop_cnt   <= '0;
        end else begin
            bus.drop_pulse <= drop;
            if (drop && bus.drop_cnt != CNT_MAX) begin
                bus.drop_cnt <= bus.drop_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_demux3_buf.sv
// tb_demux3_buf: directed scenarios plus randomized run against a port-level model.
// Second instance with DROP_CNT_W=2 shares all inputs to exercise saturation.
module tb_demux3_buf;

    logic        clk;
    logic        rst;
    logic        iv;
    logic [1:0]  isel;
    logic [31:0] idata;
    logic        rdy [3];

    demux3_buf_if #(.BITWIDTH(32), .DROP_CNT_W(8)) bus ();
    demux3_buf_if #(.BITWIDTH(32), .DROP_CNT_W(2)) bus2 ();

    assign bus.in_valid  = iv;
    assign bus.in_sel    = isel;
    assign bus.in_data   = idata;
    assign bus.a_ready   = rdy[0];
    assign bus.b_ready   = rdy[1];
    assign bus.c_ready   = rdy[2];
    assign bus2.in_valid = iv;
    assign bus2.in_sel   = isel;
    assign bus2.in_data  = idata;
    assign bus2.a_ready  = rdy[0];
    assign bus2.b_ready  = rdy[1];
    assign bus2.c_ready  = rdy[2];

    demux3_buf #(.BITWIDTH(32), .DROP_CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    demux3_buf #(.BITWIDTH(32), .DROP_CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    logic        ov [3];
    logic [31:0] od [3];
    assign ov[0] = bus.a_valid;
    assign ov[1] = bus.b_valid;
    assign ov[2] = bus.c_valid;
    assign od[0] = bus.a_data;
    assign od[1] = bus.b_data;
    assign od[2] = bus.c_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Port-level reference: a one-word buffer per port plus drop counters.
    logic        mv [3];
    logic [31:0] md [3];
    logic        mpulse;
    logic [7:0]  mcnt;
    logic [1:0]  mcnt2;

    function automatic logic model_ready();
        if (isel == 2'b11) return 1'b1;
        return !mv[isel] || rdy[isel];
    endfunction

    // Update model from current inputs, then advance one clock edge.
    task automatic step();
        logic er;
        er = model_ready();
        if (rst) begin
            for (int p = 0; p < 3; p++) begin
                mv[p] = 1'b0;
                md[p] = '0;
            end
            mpulse = 1'b0;
            mcnt   = '0;
            mcnt2  = '0;
        end else begin
            for (int p = 0; p < 3; p++) begin
                if (iv && er && int'(isel) == p) begin
                    mv[p] = 1'b1;
                    md[p] = idata;
                end else if (mv[p] && rdy[p]) begin
                    mv[p] = 1'b0;
                end
            end
            mpulse = iv && (isel == 2'b11);
            if (mpulse && mcnt != 8'hff) mcnt = mcnt + 1'b1;
            if (mpulse && mcnt2 != 2'b11) mcnt2 = mcnt2 + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        iv  = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        iv     = 1'b0;
        isel   = 2'b00;
        idata  = '0;
        rdy[0] = 1'b0;
        rdy[1] = 1'b0;
        rdy[2] = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (ov[p] !== 1'b0 || od[p] !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_port%0d: valid=%b data=%h required valid=0 data=0",
                         p, ov[p], od[p]);
            end
        end
        n_checks++;
        if (bus.drop_cnt !== 8'h0 || bus.drop_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_drop: cnt=%0d pulse=%b required 0/0",
                     bus.drop_cnt, bus.drop_pulse);
        end
        for (int s = 0; s < 4; s++) begin
            isel = 2'(s);
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset_in_ready sel=%0d: got %b required 1",
                         s, bus.in_ready);
            end
        end
    endtask

    task automatic test_single_route();
        isel  = 2'b01;
        idata = 32'hdeadbeef;
        iv    = 1'b1;
        step();
        iv = 1'b0;
        n_checks++;
        if (bus.b_valid !== 1'b1 || bus.b_data !== 32'hdeadbeef) begin
            n_fail++;
            $display("FAIL route_b: valid=%b data=%h required 1/deadbeef",
                     bus.b_valid, bus.b_data);
        end
        n_checks++;
        if (bus.a_valid !== 1'b0 || bus.c_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL route_others: a=%b c=%b required 0/0",
                     bus.a_valid, bus.c_valid);
        end
        iv    = 1'b1;
        idata = 32'h12345678;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL route_stall: in_ready=%b required 0", bus.in_ready);
        end
        step();
        n_checks++;
        if (bus.b_data !== 32'hdeadbeef) begin
            n_fail++;
            $display("FAIL route_hold: data=%h required deadbeef", bus.b_data);
        end
        rdy[1] = 1'b1;
        #1;
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL route_unstall: in_ready=%b required 1", bus.in_ready);
        end
        step();
        iv = 1'b0;
        n_checks++;
        if (bus.b_valid !== 1'b1 || bus.b_data !== 32'h12345678) begin
            n_fail++;
            $display("FAIL route_refill: valid=%b data=%h required 1/12345678",
                     bus.b_valid, bus.b_data);
        end
        step();
        n_checks++;
        if (bus.b_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL route_drain: valid=%b required 0", bus.b_valid);
        end
        rdy[1] = 1'b0;
    endtask

    task automatic test_back_to_back();
        isel   = 2'b10;
        rdy[2] = 1'b1;
        iv     = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            idata = 32'(i);
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_in_ready word%0d: got %b required 1",
                         i, bus.in_ready);
            end
            step();
            n_checks++;
            if (bus.c_valid !== 1'b1 || bus.c_data !== 32'(i)) begin
                n_fail++;
                $display("FAIL b2b_word%0d: valid=%b data=%h required 1/%h",
                         i, bus.c_valid, bus.c_data, 32'(i));
            end
        end
        iv = 1'b0;
        step();
        n_checks++;
        if (bus.c_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_empty: valid=%b required 0", bus.c_valid);
        end
        rdy[2] = 1'b0;
    endtask

    task automatic test_invalid();
        int pulses;
        do_reset();
        pulses = 0;
        isel   = 2'b11;
        iv     = 1'b1;
        for (int i = 0; i < 5; i++) begin
            idata = $urandom;
            #1;
            n_checks++;
            if (bus.in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL inv_in_ready word%0d: got %b required 1",
                         i, bus.in_ready);
            end
            step();
            if (bus.drop_pulse === 1'b1) pulses++;
            n_checks++;
            if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0 ||
                bus.c_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL inv_no_slot word%0d: a=%b b=%b c=%b required 0",
                         i, bus.a_valid, bus.b_valid, bus.c_valid);
            end
        end
        iv = 1'b0;
        step();
        n_checks++;
        if (pulses != 5 || bus.drop_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_pulses: pulses=%0d trailing=%b required 5/0",
                     pulses, bus.drop_pulse);
        end
        n_checks++;
        if (bus.drop_cnt !== 8'd5) begin
            n_fail++;
            $display("FAIL inv_cnt: got %0d required 5", bus.drop_cnt);
        end
        n_checks++;
        if (bus2.drop_cnt !== 2'd3) begin
            n_fail++;
            $display("FAIL inv_cnt_sat: got %0d required 3", bus2.drop_cnt);
        end
    endtask

    task automatic test_parallel_drain();
        logic [31:0] vals [3];
        vals[0] = 32'h11;
        vals[1] = 32'h22;
        vals[2] = 32'h33;
        for (int p = 0; p < 3; p++) rdy[p] = 1'b0;
        iv = 1'b1;
        for (int p = 0; p < 3; p++) begin
            isel  = 2'(p);
            idata = vals[p];
            step();
        end
        iv = 1'b0;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (ov[p] !== 1'b1 || od[p] !== vals[p]) begin
                n_fail++;
                $display("FAIL fill_port%0d: valid=%b data=%h required 1/%h",
                         p, ov[p], od[p], vals[p]);
            end
        end
        for (int p = 0; p < 3; p++) rdy[p] = 1'b1;
        step();
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (ov[p] !== 1'b0 || od[p] !== vals[p]) begin
                n_fail++;
                $display("FAIL drain_port%0d: valid=%b data=%h required 0/%h",
                         p, ov[p], od[p], vals[p]);
            end
        end
        for (int p = 0; p < 3; p++) rdy[p] = 1'b0;
    endtask

    task automatic test_reset_mid();
        isel  = 2'b11;
        iv    = 1'b1;
        step();
        isel  = 2'b01;
        idata = 32'h55;
        step();
        n_checks++;
        if (bus.b_valid !== 1'b1 || bus.drop_cnt === 8'd0) begin
            n_fail++;
            $display("FAIL mid_setup: b_valid=%b cnt=%0d required 1/nonzero",
                     bus.b_valid, bus.drop_cnt);
        end
        rst   = 1'b1;
        isel  = 2'b00;
        idata = 32'h99;
        step();
        rst = 1'b0;
        iv  = 1'b0;
        for (int p = 0; p < 3; p++) begin
            n_checks++;
            if (ov[p] !== 1'b0 || od[p] !== 32'h0) begin
                n_fail++;
                $display("FAIL mid_port%0d: valid=%b data=%h required 0/0",
                         p, ov[p], od[p]);
            end
        end
        n_checks++;
        if (bus.drop_cnt !== 8'd0 || bus.drop_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_drop: cnt=%0d pulse=%b required 0/0",
                     bus.drop_cnt, bus.drop_pulse);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 63) == 0);
            iv     = $urandom_range(0, 3) != 0;
            isel   = 2'($urandom_range(0, 3));
            idata  = $urandom;
            rdy[0] = $urandom_range(0, 1) == 1;
            rdy[1] = $urandom_range(0, 1) == 1;
            rdy[2] = $urandom_range(0, 1) == 1;
            #1;
            n_checks++;
            if (bus.in_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL rand_in_ready cyc%0d: got %b required %b",
                         n, bus.in_ready, model_ready());
            end
            step();
            for (int p = 0; p < 3; p++) begin
                n_checks++;
                if (ov[p] !== mv[p] || od[p] !== md[p]) begin
                    n_fail++;
                    $display("FAIL rand_port%0d cyc%0d: %b/%h required %b/%h",
                             p, n, ov[p], od[p], mv[p], md[p]);
                end
            end
            n_checks++;
            if (bus.drop_pulse !== mpulse || bus.drop_cnt !== mcnt ||
                bus2.drop_cnt !== mcnt2) begin
                n_fail++;
                $display("FAIL rand_drop cyc%0d: %b/%0d/%0d required %b/%0d/%0d",
                         n, bus.drop_pulse, bus.drop_cnt, bus2.drop_cnt,
                         mpulse, mcnt, mcnt2);
            end
        end
        rst = 1'b0;
        iv  = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_route();
        test_back_to_back();
        test_invalid();
        test_parallel_drain();
        test_reset_mid();
        do_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
